// File: rtl/noc_pkt_tx.sv
// ============================================================================
// noc_pkt_tx : per-type request queues, round-robin arbiter, packet out reg
// Rev 1.0
// ============================================================================
`default_nettype none

module noc_pkt_tx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             src_valid_i,
  output logic             src_ready_o,
  input  logic [1:0]       src_type_i,
  input  logic [1:0]       src_addr_i,
  input  logic [7:0]       src_payload_i,
  output logic [12:0]      packet_o,
  output logic             pack_valid_o,
  input  logic             nocr_ready_i,
  output logic [3:0]       q_full_o,
  output logic [3:0]       q_empty_o,
  output logic [CNT_W-1:0] sent_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [12:0]      packet_q, packet_d;
  logic [1:0]       rr_q, rr_d;
  logic [CNT_W-1:0] sent_q, sent_d;

  logic [3:0] full, empty, push, pop;
  logic [9:0] head [4];
  logic [1:0] grant;
  logic [1:0] idx;
  logic       found;
  logic       load;

  assign src_ready_o = ~full[src_type_i];
  assign push = (src_valid_i && src_ready_o) ? (4'b0001 << src_type_i) : 4'b0000;
  assign pop  = load ? (4'b0001 << grant) : 4'b0000;

  // Each queue entry holds {payload, addr}; the type is implied by the queue.
  for (genvar t = 0; t < 4; t++) begin : g_q
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push[t]) begin
          mem_q[wr_q] <= {src_payload_i, src_addr_i};
          wr_q        <= wr_q + 1'b1;
        end
        if (pop[t]) rd_q <= rd_q + 1'b1;
        if (push[t] && !pop[t])      cnt_q <= cnt_q + 1'b1;
        else if (!push[t] && pop[t]) cnt_q <= cnt_q - 1'b1;
      end
    end

    assign full[t]  = (cnt_q == CW'(DEPTH));
    assign empty[t] = (cnt_q == '0);
    assign head[t]  = mem_q[rd_q];
  end

  // First non-empty queue at or after rr_q, wrapping 3 -> 0.
  always_comb begin
    grant = rr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign load = ((state_q == IDLE) || nocr_ready_i) && found;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      packet_q <= '0;
      rr_q     <= '0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      packet_q <= packet_d;
      rr_q     <= rr_d;
      sent_q   <= sent_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    packet_d = packet_q;
    rr_d     = rr_q;
    sent_d   = sent_q;
    if ((state_q == SEND) && nocr_ready_i) sent_d = sent_q + 1'b1;
    if (load) begin
      state_d  = SEND;
      packet_d = {1'b1, head[grant][9:2], grant, head[grant][1:0]};
      rr_d     = grant + 2'd1;
    end else if ((state_q == SEND) && nocr_ready_i) begin
      state_d = IDLE;
    end
  end

  assign packet_o     = packet_q;
  assign pack_valid_o = (state_q == SEND);
  assign q_full_o     = full;
  assign q_empty_o    = empty;
  assign sent_count_o = sent_q;

endmodule

`default_nettype wire

// File: tb/tb_noc_pkt_tx.sv
// ============================================================================
// tb_noc_pkt_tx : directed self-checking bench for noc_pkt_tx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_noc_pkt_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        src_valid;
  logic        src_ready;
  logic [1:0]  src_type;
  logic [1:0]  src_addr;
  logic [7:0]  src_payload;
  logic [12:0] packet;
  logic        pack_valid;
  logic        nocr_ready;
  logic [3:0]  q_full;
  logic [3:0]  q_empty;
  logic [15:0] sent_count;

  int n_checks = 0;
  int n_pass   = 0;

  noc_pkt_tx #(.DEPTH(4), .CNT_W(16)) u_dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready),
    .src_type_i   (src_type),
    .src_addr_i   (src_addr),
    .src_payload_i(src_payload),
    .packet_o     (packet),
    .pack_valid_o (pack_valid),
    .nocr_ready_i (nocr_ready),
    .q_full_o     (q_full),
    .q_empty_o    (q_empty),
    .sent_count_o (sent_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [12:0] pk(input logic [1:0] t, input logic [1:0] a, input logic [7:0] p);
    return {1'b1, p, t, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] t, input logic [1:0] a, input logic [7:0] p);
    src_valid   = 1'b1;
    src_type    = t;
    src_addr    = a;
    src_payload = p;
    tick();
    src_valid   = 1'b0;
  endtask

  logic [12:0] exp_pk [7];

  initial begin
    reset_n     = 1'b0;
    src_valid   = 1'b0;
    src_type    = 2'd0;
    src_addr    = 2'd0;
    src_payload = 8'h00;
    nocr_ready  = 1'b0;
    @(negedge clk);

    // Reset
    tick(); tick();
    check("rst_pv", pack_valid, 0);
    check("rst_pkt", packet, 0);
    check("rst_empty", q_empty, 4'hF);
    check("rst_full", q_full, 4'h0);
    check("rst_cnt", sent_count, 0);
    check("rst_srdy", src_ready, 1);
    reset_n = 1'b1;
    tick();
    check("idle_pv", pack_valid, 0);

    // Single packet, latency
    nocr_ready = 1'b1;
    push(2'd0, 2'd2, 8'hA5);
    check("t2_empty", q_empty, 4'hE);
    check("t2_pv0", pack_valid, 0);
    tick();
    check("t2_pv1", pack_valid, 1);
    check("t2_pkt", packet, 13'h1A52);
    check("t2_cnt0", sent_count, 0);
    check("t2_empty2", q_empty, 4'hF);
    tick();
    check("t2_cnt1", sent_count, 1);
    check("t2_pvoff", pack_valid, 0);

    // Round-robin with stall, from a fresh reset (rr_ptr=0)
    reset_n = 1'b0;
    tick();
    reset_n    = 1'b1;
    nocr_ready = 1'b0;
    push(2'd3, 2'd3, 8'h33);
    push(2'd1, 2'd1, 8'h31);
    check("t3_first", packet, pk(2'd3, 2'd3, 8'h33));
    push(2'd0, 2'd0, 8'h30);
    push(2'd2, 2'd2, 8'h32);
    tick();
    check("t3_hold_pkt", packet, pk(2'd3, 2'd3, 8'h33));
    check("t3_hold_pv", pack_valid, 1);
    check("t3_hold_cnt", sent_count, 0);
    nocr_ready = 1'b1;
    tick();
    check("t3_o0", packet, pk(2'd0, 2'd0, 8'h30));
    tick();
    check("t3_o1", packet, pk(2'd1, 2'd1, 8'h31));
    tick();
    check("t3_o2", packet, pk(2'd2, 2'd2, 8'h32));
    check("t3_cnt3", sent_count, 3);
    tick();
    check("t3_pvoff", pack_valid, 0);
    check("t3_cnt4", sent_count, 4);

    // Fill type 1 while stalled; rr_ptr is 3 here
    nocr_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(2'd1, 2'd0, 8'h40 + 8'(k));
    check("t4_pkt", packet, pk(2'd1, 2'd0, 8'h40));
    check("t4_full", q_full, 4'b0010);
    src_valid   = 1'b1;
    src_type    = 2'd1;
    src_payload = 8'h45;
    #1;
    check("t4_rdy1", src_ready, 0);
    tick();
    src_type    = 2'd2;
    src_addr    = 2'd2;
    src_payload = 8'h52;
    #1;
    check("t4_rdy2", src_ready, 1);
    tick();
    src_valid = 1'b0;
    check("t4_empty", q_empty, 4'b1001);
    push(2'd0, 2'd1, 8'h05);
    push(2'd3, 2'd0, 8'hF3);
    check("t4_empty2", q_empty, 4'b0000);
    check("t4_full2", q_full, 4'b0010);

    // Back-to-back drain, starting from rr_ptr=2
    exp_pk[0] = pk(2'd2, 2'd2, 8'h52);
    exp_pk[1] = pk(2'd3, 2'd0, 8'hF3);
    exp_pk[2] = pk(2'd0, 2'd1, 8'h05);
    exp_pk[3] = pk(2'd1, 2'd0, 8'h41);
    exp_pk[4] = pk(2'd1, 2'd0, 8'h42);
    exp_pk[5] = pk(2'd1, 2'd0, 8'h43);
    exp_pk[6] = pk(2'd1, 2'd0, 8'h44);
    nocr_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("t5_pkt%0d", k), packet, exp_pk[k]);
      check($sformatf("t5_cnt%0d", k), sent_count, 32'd5 + 32'(k));
    end
    tick();
    check("t5_pvoff", pack_valid, 0);
    check("t5_empty", q_empty, 4'hF);
    check("t5_cnt", sent_count, 12);

    // Reset mid-transfer
    nocr_ready = 1'b0;
    push(2'd0, 2'd0, 8'h11);
    push(2'd0, 2'd0, 8'h12);
    push(2'd2, 2'd1, 8'h22);
    check("t6_pv", pack_valid, 1);
    reset_n = 1'b0;
    tick();
    check("t6_pv0", pack_valid, 0);
    check("t6_pkt", packet, 0);
    check("t6_empty", q_empty, 4'hF);
    check("t6_cnt", sent_count, 0);
    reset_n = 1'b1;
    tick();
    check("t6_pv_after", pack_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
